// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Both ready and valid are decoded from registered state, so no combinational ready path exists.
module pipe_stage_skid_reg #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 101
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;

  logic in_fire, out_fire;
  logic load_main, main_from_skid, load_skid;

  always_comb begin
    Out_Valid = 1'b0;
    In_Ready  = 1'b1;
    Occupancy = 2'd0;
    unique case (state_q)
      StEmpty: begin
        Out_Valid = 1'b0;
        In_Ready  = 1'b1;
        Occupancy = 2'd0;
      end
      StOne: begin
        Out_Valid = 1'b1;
        In_Ready  = 1'b1;
        Occupancy = 2'd1;
      end
      StFull: begin
        Out_Valid = 1'b1;
        In_Ready  = 1'b0;
        Occupancy = 2'd2;
      end
      default: begin
        Out_Valid = 1'b0;
        In_Ready  = 1'b1;
        Occupancy = 2'd0;
      end
    endcase
  end

  assign in_fire  = In_Valid & In_Ready;
  assign out_fire = Out_Valid & Out_Ready;

  // Bubbles always present an all-zero control bundle.
  assign Out_Ctrl = Out_Valid ? main_ctrl_q : '0;
  assign Out_Data = main_data_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (Flush) begin
      // A simultaneous accept is dropped; a simultaneous consume is simply gone.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d   = StOne;
            load_main = 1'b1;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            state_d   = StFull;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d        = StOne;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_main) begin
        main_ctrl_q <= main_from_skid ? skid_ctrl_q : In_Ctrl;
        main_data_q <= main_from_skid ? skid_data_q : In_Data;
      end
      if (load_skid) begin
        skid_ctrl_q <= In_Ctrl;
        skid_data_q <= In_Data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_skid_reg;
  localparam int unsigned CTRL_W = 4;
  localparam int unsigned DATA_W = 101;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Flush = 1'b0;
  logic              In_Valid = 1'b0;
  logic              In_Ready;
  logic [CTRL_W-1:0] In_Ctrl = '0;
  logic [DATA_W-1:0] In_Data = '0;
  logic              Out_Valid;
  logic              Out_Ready = 1'b0;
  logic [CTRL_W-1:0] Out_Ctrl;
  logic [DATA_W-1:0] Out_Data;
  logic [1:0]        Occupancy;

  int tests = 0;
  int fails = 0;
  ent_t q[$];

  pipe_stage_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Ctrl(In_Ctrl), .In_Data(In_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Ctrl(Out_Ctrl), .Out_Data(Out_Data), .Occupancy(Occupancy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    ent_t h;
    check({tag, ".valid"}, 128'(Out_Valid), 128'(q.size() > 0));
    check({tag, ".ready"}, 128'(In_Ready), 128'(q.size() < 2));
    check({tag, ".occ"}, 128'(Occupancy), 128'(q.size()));
    if (q.size() > 0) begin
      h = q[0];
      check({tag, ".ctrl"}, 128'(Out_Ctrl), 128'(h.c));
      check({tag, ".data"}, 128'(Out_Data), 128'(h.d));
    end else begin
      check({tag, ".ctrl0"}, 128'(Out_Ctrl), 128'(0));
    end
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, then compare.
  task automatic cycle(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                       input logic ordy, input logic fl, input string tag);
    bit   acc, con;
    ent_t e;
    In_Valid  = v;
    In_Ctrl   = c;
    In_Data   = d;
    Out_Ready = ordy;
    Flush     = fl;
    acc = v && (q.size() < 2);
    con = ordy && (q.size() > 0);
    e.c = c;
    e.d = d;
    @(posedge Clk);
    #1;
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    check_model(tag);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[DATA_W-1:0];
  endfunction

  initial begin
    logic              v, ordy, fl;
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
    bit                hold;

    // Reset state
    #2;
    check("rst.valid", 128'(Out_Valid), 128'(0));
    check("rst.ready", 128'(In_Ready), 128'(1));
    check("rst.occ", 128'(Occupancy), 128'(0));
    check("rst.data", 128'(Out_Data), 128'(0));
    @(negedge Clk);
    Reset = 1'b1;

    // Stream 1..8 with no backpressure: each value visible one cycle after accept
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 4'(i), DATA_W'(i), 1'b1, 1'b0, "stream");
      check("stream.out", 128'(Out_Data), 128'(i));
      check("stream.occ1", 128'(Occupancy), 128'(1));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "drain");

    // Backpressure: A then B with output stalled
    cycle(1'b1, 4'h1, DATA_W'(16'hA), 1'b0, 1'b0, "bp.a");
    cycle(1'b1, 4'h2, DATA_W'(16'hB), 1'b0, 1'b0, "bp.b");
    check("bp.full", 128'(Occupancy), 128'(2));
    check("bp.noready", 128'(In_Ready), 128'(0));
    check("bp.head", 128'(Out_Data), 128'(16'hA));
    // FULL with Out_Ready and a pending C: A leaves, B next, C accepted after
    cycle(1'b1, 4'h3, DATA_W'(16'hC), 1'b1, 1'b0, "fullc.1");
    check("fullc.b", 128'(Out_Data), 128'(16'hB));
    cycle(1'b1, 4'h3, DATA_W'(16'hC), 1'b1, 1'b0, "fullc.2");
    check("fullc.c", 128'(Out_Data), 128'(16'hC));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "fullc.3");

    // Flush while FULL with an incoming entry
    cycle(1'b1, 4'h5, DATA_W'(16'h11), 1'b0, 1'b0, "fl.a");
    cycle(1'b1, 4'h6, DATA_W'(16'h22), 1'b0, 1'b0, "fl.b");
    cycle(1'b1, 4'h7, DATA_W'(16'h33), 1'b0, 1'b1, "fl.f");
    check("fl.occ", 128'(Occupancy), 128'(0));
    check("fl.ctrl", 128'(Out_Ctrl), 128'(0));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "fl.idle");

    // Control 4'hF for one cycle, then a zero bubble
    cycle(1'b1, 4'hF, DATA_W'(16'h55), 1'b1, 1'b0, "ctl.f");
    check("ctl.fval", 128'(Out_Ctrl), 128'(4'hF));
    cycle(1'b0, '0, '0, 1'b1, 1'b0, "ctl.bub");
    check("ctl.zero", 128'(Out_Ctrl), 128'(0));

    // Asynchronous reset mid-FULL, checked without a clock edge
    cycle(1'b1, 4'h9, DATA_W'(16'h77), 1'b0, 1'b0, "ar.a");
    cycle(1'b1, 4'hA, DATA_W'(16'h88), 1'b0, 1'b0, "ar.b");
    In_Valid = 1'b0;
    Reset = 1'b0;
    #1;
    q.delete();
    check("ar.valid", 128'(Out_Valid), 128'(0));
    check("ar.ctrl", 128'(Out_Ctrl), 128'(0));
    check("ar.data", 128'(Out_Data), 128'(0));
    check("ar.ready", 128'(In_Ready), 128'(1));
    check("ar.occ", 128'(Occupancy), 128'(0));
    #1;
    Reset = 1'b1;

    // Random traffic; upstream holds its offer while it is not accepted
    hold = 1'b0;
    c = '0;
    d = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        c = 4'($urandom());
        d = rand_data();
      end
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      hold = v && (q.size() >= 2) && !fl;
      cycle(v, c, d, ordy, fl, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
